// File: rtl/tlul_cdc_host_arbiter.sv
// tlul_cdc_host_arbiter
//   Round-robin arbiter that lets several 100 MHz hosts share the single
//   main-to-peripheral TL-UL CDC crossing, one transaction in flight at a time.
//   D-channel responses are steered by the grant register, not by d_source.
//   Optional feature macro: TLUL_CDC_ARB_TIMEOUT_EN
//     defined   -> issue-to-response watchdog, error response to the host and
//                  a drain state that absorbs the late downstream traffic.
//     undefined -> no watchdog; WAIT waits indefinitely; timeout_o tied low.

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_cdc_host_arbiter #(
    parameter int unsigned NumHosts      = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                 clk_main_i,
    input  logic                                 rst_ni,
    input  tlul_pkg::tl_h2d_t [NumHosts-1:0]     tl_h2d_i,
    output tlul_pkg::tl_d2h_t [NumHosts-1:0]     tl_d2h_o,
    output tlul_pkg::tl_h2d_t                    tl_h2d_o,
    input  tlul_pkg::tl_d2h_t                    tl_d2h_i,
    output logic [$clog2(NumHosts)-1:0]          grant_o,
    output logic                                 busy_o,
    output logic                                 timeout_o
);

    localparam int unsigned GW = $clog2(NumHosts);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam int unsigned CntW   = $clog2(TimeoutCycles);
`endif

    // Configurations outside the supported range are rejected at elaboration.
    if (NumHosts < 2 || NumHosts > 8 || TimeoutCycles < 4) begin : g_bad_cfg
        $error("tlul_cdc_host_arbiter: unsupported NumHosts/TimeoutCycles");
    end

    logic [2:0]          r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last_grant;
    tlul_pkg::tl_h2d_t   r_req;

    logic [NumHosts-1:0] w_avalid;
    logic [NumHosts-1:0] w_hdready;
    logic                w_any;
    logic [GW-1:0]       w_win;
    logic                w_gnt_dready;
    logic                w_d_hs;
    logic                w_tmo;

`ifdef TLUL_CDC_ARB_TIMEOUT_EN
    logic [CntW-1:0]     r_cnt;
    logic                r_a_done;
`endif

    assign w_gnt_dready = w_hdready[r_grant];
    assign w_d_hs       = (r_state == S_WAIT) && tl_d2h_i.d_valid && w_gnt_dready;

    // Round-robin search starting one past the last winner
    always_comb begin
        logic [GW-1:0] v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_idx = '0;
        for (int unsigned i = 1; i <= NumHosts; i++) begin
            v_idx = GW'((32'(r_last_grant) + i) % NumHosts);
            if (!w_any && w_avalid[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
    end

`ifdef TLUL_CDC_ARB_TIMEOUT_EN
    // Watchdog fires on the last allowed cycle unless the response lands then
    assign w_tmo = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                   (r_cnt == CntW'(TimeoutCycles - 1)) && !w_d_hs;
`else
    assign w_tmo = 1'b0;
`endif

    // Per-host response steering and a_ready to the round-robin winner
    for (genvar h = 0; h < NumHosts; h++) begin : g_host
        tlul_pkg::tl_d2h_t w_rsp;

        assign w_avalid[h]  = tl_h2d_i[h].a_valid;
        assign w_hdready[h] = tl_h2d_i[h].d_ready;
        assign tl_d2h_o[h]  = w_rsp;

        // Only the granted host ever sees D traffic; gated low during reset
        always_comb begin
            w_rsp = '0;
            if (rst_ni) begin
                if (r_state == S_IDLE && w_any && w_win == GW'(h)) begin
                    w_rsp.a_ready = 1'b1;
                end
                if (r_grant == GW'(h)) begin
                    if (r_state == S_WAIT) begin
                        w_rsp         = tl_d2h_i;
                        w_rsp.a_ready = 1'b0;
                    end
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
                    else if (r_state == S_ERR) begin
                        w_rsp.d_valid  = 1'b1;
                        w_rsp.d_error  = 1'b1;
                        w_rsp.d_opcode = (r_req.a_opcode == tlul_pkg::Get) ?
                                         tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
                        w_rsp.d_source = r_req.a_source;
                        w_rsp.d_size   = r_req.a_size;
                        w_rsp.d_data   = '0;
                    end
`endif
                end
            end
        end
    end

    // Downstream request: held A fields plus state-dependent valid/ready
    always_comb begin
        tl_h2d_o         = r_req;
        tl_h2d_o.a_valid = 1'b0;
        tl_h2d_o.d_ready = 1'b0;
        if (rst_ni) begin
            case (r_state)
                S_ISSUE: tl_h2d_o.a_valid = 1'b1;
                S_WAIT:  tl_h2d_o.d_ready = w_gnt_dready;
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
                // A request may still be pending when the watchdog fired
                S_ERR:   tl_h2d_o.a_valid = !r_a_done;
                S_DRAIN: begin
                    tl_h2d_o.a_valid = !r_a_done;
                    tl_h2d_o.d_ready = r_a_done;
                end
`endif
                default: ;
            endcase
        end
    end

    // Main transaction FSM, grant bookkeeping and A-field capture
    always_ff @(posedge clk_main_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NumHosts - 1);
            r_req        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_ISSUE;
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        r_req        <= tl_h2d_i[w_win];
                    end
                end
                S_ISSUE: begin
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
                    if (w_tmo)                 r_state <= S_ERR;
                    else
`endif
                    if (tl_d2h_i.a_ready)      r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_d_hs)                r_state <= S_IDLE;
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
                    else if (w_tmo)            r_state <= S_ERR;
`endif
                end
`ifdef TLUL_CDC_ARB_TIMEOUT_EN
                S_ERR: begin
                    if (w_gnt_dready)          r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_a_done && tl_d2h_i.d_valid) r_state <= S_IDLE;
                end
`endif
                default:                       r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TLUL_CDC_ARB_TIMEOUT_EN
    // Issue-to-response cycle counter, restarted whenever a new grant issues
    always_ff @(posedge clk_main_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any) r_cnt <= '0;
        end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Remembers whether the downstream already took the A beat
    always_ff @(posedge clk_main_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_done <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_a_done <= 1'b0;
        end else if (r_state == S_ISSUE || r_state == S_ERR || r_state == S_DRAIN) begin
            if (!r_a_done && tl_d2h_i.a_ready) r_a_done <= 1'b1;
        end
    end
`endif

    assign grant_o   = r_grant;
    assign busy_o    = (r_state != S_IDLE);
    assign timeout_o = w_tmo;

endmodule

// File: tb/tb_tlul_cdc_host_arbiter.sv
// Directed bench for tlul_cdc_host_arbiter: a vector table of arbitration /
// response cases plus hand sequences for reset, backpressure and watchdog.
module tb_tlul_cdc_host_arbiter;
    import tlul_pkg::*;

    localparam int NH = 4;

    logic             clk_main_i = 1'b0;
    logic             rst_ni     = 1'b0;
    tl_h2d_t [NH-1:0] h2d;
    tl_d2h_t [NH-1:0] d2h;
    tl_h2d_t          dn_h2d;
    tl_d2h_t          dn_d2h;
    logic [1:0]       grant;
    logic             busy;
    logic             tmo;
    logic [NH-1:0]    rdy_v;
    logic [NH-1:0]    dv_v;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_main_i = ~clk_main_i;

    tlul_cdc_host_arbiter #(.NumHosts(NH), .TimeoutCycles(16)) dut (
        .clk_main_i (clk_main_i),
        .rst_ni     (rst_ni),
        .tl_h2d_i   (h2d),
        .tl_d2h_o   (d2h),
        .tl_h2d_o   (dn_h2d),
        .tl_d2h_i   (dn_d2h),
        .grant_o    (grant),
        .busy_o     (busy),
        .timeout_o  (tmo)
    );

    for (genvar g = 0; g < NH; g++) begin : g_v
        assign rdy_v[g] = d2h[g].a_ready;
        assign dv_v[g]  = d2h[g].d_valid;
    end

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  win;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          dly;
        int          hold;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_main_i);
        #1;
    endtask

    // One full transaction: arbitration, issue, optional host backpressure, response
    task automatic do_txn(input vec_t v);
        for (int h = 0; h < NH; h++) begin
            if (v.mask[h]) begin
                h2d[2'(h)].a_valid   = 1'b1;
                h2d[2'(h)].a_opcode  = v.op;
                h2d[2'(h)].a_size    = 2'd2;
                h2d[2'(h)].a_source  = 8'h10 + 8'(h);
                h2d[2'(h)].a_address = v.addr + 32'(h - int'(v.win)) * 32'h1000;
            end
        end
        #1;
        chk("arb_ready", 64'(rdy_v), 64'(4'b1 << v.win));
        chk("idle_busy", 64'(busy), 64'd0);
        step();
        for (int h = 0; h < NH; h++) h2d[2'(h)].a_valid = 1'b0;
        #1;
        chk("grant", 64'(grant), 64'(v.win));
        chk("issue_valid", 64'(dn_h2d.a_valid), 64'd1);
        chk("issue_addr", 64'(dn_h2d.a_address), 64'(v.addr));
        chk("issue_src", 64'(dn_h2d.a_source), 64'(8'h10 + 8'(v.win)));
        chk("issue_op", 64'(dn_h2d.a_opcode), 64'(v.op));
        dn_d2h.a_ready = 1'b1;
        step();
        dn_d2h.a_ready = 1'b0;
        #1;
        chk("wait_avalid", 64'(dn_h2d.a_valid), 64'd0);
        repeat (v.dly) step();
        dn_d2h.d_valid  = 1'b1;
        dn_d2h.d_data   = v.data;
        dn_d2h.d_opcode = (v.op == Get) ? AccessAckData : AccessAck;
        dn_d2h.d_source = 8'h10 + 8'(v.win);
        dn_d2h.d_error  = 1'b0;
        h2d[v.win].d_ready = (v.hold == 0);
        for (int k = 0; k < v.hold; k++) begin
            #1;
            chk("bp_dready", 64'(dn_h2d.d_ready), 64'd0);
            chk("bp_held", 64'(dv_v), 64'(4'b1 << v.win));
            step();
        end
        h2d[v.win].d_ready = 1'b1;
        #1;
        chk("rsp_route", 64'(dv_v), 64'(4'b1 << v.win));
        chk("rsp_data", 64'(d2h[v.win].d_data), 64'(v.data));
        chk("rsp_err", 64'(d2h[v.win].d_error), 64'd0);
        chk("rsp_dready", 64'(dn_h2d.d_ready), 64'd1);
        step();
        dn_d2h.d_valid = 1'b0;
        #1;
        chk("done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vt[0] = '{4'b0010, 2'd1, Get,         32'h0000_0040, 32'hDEAD_BEEF, 10, 0};
        vt[1] = '{4'b1111, 2'd2, PutFullData, 32'h0000_0100, 32'h1111_0001, 0, 0};
        vt[2] = '{4'b1111, 2'd3, Get,         32'h0000_0200, 32'h2222_0002, 1, 0};
        vt[3] = '{4'b1111, 2'd0, Get,         32'h0000_0300, 32'h3333_0003, 2, 0};
        vt[4] = '{4'b1111, 2'd1, PutFullData, 32'h0000_0400, 32'h4444_0004, 0, 0};
        vt[5] = '{4'b1001, 2'd3, Get,         32'h0000_0500, 32'h5555_0005, 3, 0};
        vt[6] = '{4'b1001, 2'd0, Get,         32'h0000_0600, 32'h6666_0006, 0, 0};
        vt[7] = '{4'b0001, 2'd0, PutFullData, 32'h0000_0700, 32'h7777_0007, 1, 0};
        vt[8] = '{4'b0110, 2'd1, Get,         32'h0000_0800, 32'h8888_0008, 0, 0};
        vt[9] = '{4'b0100, 2'd2, Get,         32'h0000_0900, 32'h9999_0009, 2, 5};

        h2d    = '0;
        dn_d2h = '0;
        h2d[0].a_valid = 1'b1;
        #2;
        chk("rst_ready", 64'(rdy_v), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tmo", 64'(tmo), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_avalid", 64'(dn_h2d.a_valid), 64'd0);
        chk("rst_dready", 64'(dn_h2d.d_ready), 64'd0);
        h2d = '0;
        step();
        rst_ni = 1'b1;
        for (int h = 0; h < NH; h++) h2d[2'(h)].d_ready = 1'b1;
        step();

        for (int i = 0; i < 10; i++) do_txn(vt[i]);

        // Asynchronous reset while a response is being passed through
        h2d[3].a_valid = 1'b1;
        h2d[3].a_source = 8'h13;
        step();
        h2d[3].a_valid = 1'b0;
        dn_d2h.a_ready = 1'b1;
        step();
        dn_d2h.a_ready = 1'b0;
        dn_d2h.d_valid = 1'b1;
        dn_d2h.d_data  = 32'hCAFE_0003;
        h2d[3].d_ready = 1'b0;
        #1;
        chk("pre_rst_route", 64'(dv_v), 64'b1000);
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_dvalid", 64'(dv_v), 64'd0);
        chk("arst_dready", 64'(dn_h2d.d_ready), 64'd0);
        chk("arst_avalid", 64'(dn_h2d.a_valid), 64'd0);
        dn_d2h = '0;
        h2d[3].d_ready = 1'b1;
        step();
        rst_ni = 1'b1;
        step();

        // All hosts requesting: grants rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            v = '{4'b1111, 2'(i % 4), Get, 32'h0000_A000 + 32'(i), 32'hB000_0000 + 32'(i), 1, 0};
            do_txn(v);
        end

`ifdef TLUL_CDC_ARB_TIMEOUT_EN
        // Downstream never accepts A: watchdog, error response, then drain
        h2d[1].a_valid  = 1'b1;
        h2d[1].a_opcode = PutFullData;
        h2d[1].a_source = 8'h21;
        h2d[1].a_size   = 2'd2;
        #1;
        chk("to_ready", 64'(rdy_v), 64'b0010);
        step();
        h2d[1].a_valid = 1'b0;
        for (int s = 1; s < 16; s++) begin
            #1;
            chk("to_early", 64'(tmo), 64'd0);
            step();
        end
        #1;
        chk("to_pulse", 64'(tmo), 64'd1);
        chk("to_pulse_busy", 64'(busy), 64'd1);
        step();
        #1;
        chk("err_tmo_low", 64'(tmo), 64'd0);
        chk("err_route", 64'(dv_v), 64'b0010);
        chk("err_flag", 64'(d2h[1].d_error), 64'd1);
        chk("err_op", 64'(d2h[1].d_opcode), 64'(AccessAck));
        chk("err_src", 64'(d2h[1].d_source), 64'h21);
        chk("err_size", 64'(d2h[1].d_size), 64'd2);
        chk("err_data", 64'(d2h[1].d_data), 64'd0);
        step();
        #1;
        chk("drain_hidden0", 64'(dv_v), 64'd0);
        chk("drain_avalid", 64'(dn_h2d.a_valid), 64'd1);
        chk("drain_dready0", 64'(dn_h2d.d_ready), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        dn_d2h.a_ready = 1'b1;
        step();
        dn_d2h.a_ready = 1'b0;
        #1;
        chk("drain_adone", 64'(dn_h2d.a_valid), 64'd0);
        chk("drain_dready1", 64'(dn_h2d.d_ready), 64'd1);
        dn_d2h.d_valid = 1'b1;
        dn_d2h.d_data  = 32'h0BAD_0BAD;
        #1;
        chk("drain_hidden1", 64'(dv_v), 64'd0);
        step();
        dn_d2h.d_valid = 1'b0;
        #1;
        chk("drain_idle", 64'(busy), 64'd0);
        v = '{4'b0100, 2'd2, Get, 32'h0000_C000, 32'hC0DE_0002, 1, 0};
        do_txn(v);

        // Response lands on the very last counted cycle: normal completion
        h2d[3].a_valid  = 1'b1;
        h2d[3].a_opcode = Get;
        #1;
        chk("race_ready", 64'(rdy_v), 64'b1000);
        step();
        h2d[3].a_valid = 1'b0;
        dn_d2h.a_ready = 1'b1;
        #1;
        chk("race_tmo1", 64'(tmo), 64'd0);
        step();
        dn_d2h.a_ready = 1'b0;
        for (int s = 2; s < 16; s++) begin
            #1;
            chk("race_early", 64'(tmo), 64'd0);
            step();
        end
        dn_d2h.d_valid = 1'b1;
        dn_d2h.d_data  = 32'h5EED_0015;
        #1;
        chk("race_tmo", 64'(tmo), 64'd0);
        chk("race_route", 64'(dv_v), 64'b1000);
        chk("race_data", 64'(d2h[3].d_data), 64'h5EED_0015);
        chk("race_err", 64'(d2h[3].d_error), 64'd0);
        step();
        dn_d2h.d_valid = 1'b0;
        #1;
        chk("race_idle", 64'(busy), 64'd0);
        chk("race_tmo_after", 64'(tmo), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tlul_cdc_host_arbiter.md
# tlul_cdc_host_arbiter

Round-robin arbiter sharing the single main-to-peripheral TL-UL CDC crossing among several hosts in the 100 MHz domain. Sits between the xbar_main host ports and the main-side port of the CDC adapter. Allows one outstanding transaction at a time, routes each D-channel response back to the granted host, and, when the timeout feature is compiled in, converts a stalled crossing into a TL-UL error response to the host.

## Interface
- NumHosts, 4: number of requesting hosts (2..8)
- TimeoutCycles, 1024: clk_main_i cycles allowed from issue to response (≥4)
- clk_main_i  input  1  main clock (100 MHz)
- rst_ni  input  1  reset, asynchronous, active-low
- tl_h2d_i  input  tlul_pkg::tl_h2d_t ×NumHosts  host requests
- tl_d2h_o  output  tlul_pkg::tl_d2h_t ×NumHosts  host responses
- tl_h2d_o  output  tlul_pkg::tl_h2d_t  request to CDC adapter
- tl_d2h_i  input  tlul_pkg::tl_d2h_t  response from CDC adapter
- grant_o  output  $clog2(NumHosts)  index of current/last granted host
- busy_o  output  1  transaction in flight (state ≠ IDLE)
- timeout_o  output  1  one-cycle pulse on timeout

## Operation
- States: IDLE, ISSUE, WAIT, ERR_RSP, DRAIN.
- IDLE: round-robin pick among hosts with a_valid, search starting at last_grant+1 (mod NumHosts). Winner sees a_ready=1 combinationally; A fields captured into a holding register; grant and last_grant updated; → ISSUE. No a_valid: stay.
- a_ready to every host is 0 outside IDLE and 0 to non-winners.
- ISSUE: tl_h2d_o.a_valid=1 with held fields; on a_ready → WAIT.
- WAIT: D channel pass-through to granted host: tl_d2h_o[grant].d_* = tl_d2h_i.d_*, tl_h2d_o.d_ready = tl_h2d_i[grant].d_ready. Non-granted hosts see d_valid=0. On d handshake → IDLE.
- Routing uses grant register, never d_source; a_source/d_source pass unchanged.
- ERR_RSP: host gets d_valid=1, d_error=1, d_opcode=AccessAckData if held a_opcode=Get else AccessAck, d_source=held a_source, d_size=held a_size, d_data=0; on host d_ready → DRAIN.
- DRAIN: keep a_valid until accepted if not yet accepted (tracked by a_done bit), hold d_ready=1 to downstream; discard exactly one downstream response; then → IDLE. Hosts see nothing.
- Reset: state IDLE, last_grant=NumHosts-1 (host 0 wins first), grant_o=0, counter 0, all valid/ready outputs 0, busy_o=0, timeout_o=0.

## Timing
- Host A accepted cycle 0; tl_h2d_o.a_valid asserted cycle 1 (registered).
- D path zero latency (combinational) in WAIT.
- Return to IDLE cycle after D handshake; minimum 3 cycles per transaction.
- Timeout counter cleared on entering ISSUE, increments each cycle in ISSUE/WAIT; at count TimeoutCycles-1 without D handshake that cycle → ERR_RSP next cycle, timeout_o pulses in that transition cycle.
- Simultaneous D handshake and timeout expiry: normal completion wins, no timeout.
- Timeout while in ISSUE: a_done=0, DRAIN completes A before absorbing D.
- Asynchronous reset mid-transaction aborts immediately; no response delivered.

## Configuration
- TLUL_CDC_ARB_TIMEOUT_EN defined: counter, ERR_RSP and DRAIN implemented as above.
- Undefined: no counter; WAIT waits indefinitely; ERR_RSP/DRAIN absent; timeout_o tied 0.

## Test plan
- Single host 1 Get addr 0x40, downstream responds data 0xDEADBEEF after 10 cycles -> host 1 gets d_valid with 0xDEADBEEF, d_error=0, grant_o=1, busy_o low after handshake.
- All 4 hosts assert a_valid continuously after reset -> grants in order 0,1,2,3,0; no host granted twice before others.
- Host 2 holds d_ready=0 for 5 cycles -> tl_h2d_o.d_ready=0 for those cycles, response held, completes on d_ready.
- Timeout build, TimeoutCycles=16, downstream never raises a_ready -> timeout_o pulse at cycle 16 after issue, host gets d_error=1 AccessAck for PutFullData; later a_ready plus late D absorbed, next grant proceeds normally.
- Timeout build, D handshake exactly at count 15 -> normal response, timeout_o stays 0.
- rst_ni asserted in WAIT -> all outputs 0 asynchronously; after release host 0 wins first.
